// File: rtl/yari_mem_arb.sv
// Two-master memory arbiter: instruction line fills and data-side single-word accesses share one memory port.
// Optional YARI_MEM_ARB_RR_EN selects round-robin arbitration instead of fixed data-first priority.
module yari_mem_arb #(
    parameter int BURST_BITS = 3,
    parameter int ADDR_W     = 30
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     i_address,
    input  logic                  i_read,
    output logic                  i_waitrequest,
    output logic [31:0]           i_readdata,
    output logic                  i_readdatavalid,
    input  logic [ADDR_W-1:0]     d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [31:0]           d_writedata,
    input  logic [3:0]            d_byteenable,
    output logic                  d_waitrequest,
    output logic [31:0]           d_readdata,
    output logic                  d_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    output logic [3:0]            mem_byteenable,
    output logic [BURST_BITS:0]   mem_burstcount,
    input  logic                  mem_waitrequest,
    input  logic [31:0]           mem_readdata,
    input  logic                  mem_readdatavalid,
    output logic [31:0]           perf_mem_conflicts,
    output logic                  err_stray_beat
);

    localparam int                BURST_LEN_INT = 1 << BURST_BITS;
    localparam logic [BURST_BITS:0] BURST_LEN   = BURST_LEN_INT[BURST_BITS:0];
    localparam logic [BURST_BITS:0] ONE_BEAT    = {{BURST_BITS{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, I_CMD, D_CMD, I_DATA, D_DATA} state_e;

    state_e              state_q, state_d;
    logic [BURST_BITS:0] beat_q, beat_d;
    logic [31:0]         perf_q, perf_d;
    logic                stray_q, stray_d;
`ifdef YARI_MEM_ARB_RR_EN
    logic                prefer_d_q, prefer_d_d;
`endif

    logic d_req;
    logic grant_i;
    logic grant_d;
    logic cmd_phase;
    logic issue_i;
    logic issue_d;

    // Grant selection: combinational in IDLE, locked while a command is stalled.
    always_comb begin
        d_req   = d_read | d_write;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef YARI_MEM_ARB_RR_EN
                grant_i = i_read & (~d_req | ~prefer_d_q);
`else
                grant_i = i_read & ~d_req;
`endif
                grant_d = ~grant_i;
            end
            I_CMD:   grant_i = 1'b1;
            D_CMD:   grant_d = 1'b1;
            default: ;
        endcase
        cmd_phase = reset_n & ((state_q == IDLE) | (state_q == I_CMD) | (state_q == D_CMD));
        issue_i   = cmd_phase & grant_i & i_read;
        issue_d   = cmd_phase & grant_d & d_req;
    end

    always_comb begin
        mem_address     = grant_i ? i_address : d_address;
        mem_read        = issue_i | (issue_d & d_read);
        mem_write       = issue_d & d_write;
        mem_writedata   = d_writedata;
        mem_byteenable  = grant_i ? 4'hF : d_byteenable;
        mem_burstcount  = grant_i ? BURST_LEN : ONE_BEAT;
        i_waitrequest   = ~(cmd_phase & grant_i) | mem_waitrequest;
        d_waitrequest   = ~(cmd_phase & grant_d) | mem_waitrequest;
        i_readdata      = mem_readdata;
        d_readdata      = mem_readdata;
        i_readdatavalid = reset_n & (state_q == I_DATA) & mem_readdatavalid;
        d_readdatavalid = reset_n & (state_q == D_DATA) & mem_readdatavalid;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        stray_d = stray_q;
        perf_d  = perf_q;
`ifdef YARI_MEM_ARB_RR_EN
        prefer_d_d = prefer_d_q;
        if ((issue_i | issue_d) & ~mem_waitrequest) begin
            prefer_d_d = issue_i;
        end
`endif
        if ((state_q == IDLE) & i_read & d_req) begin
            perf_d = perf_q + 32'd1;
        end
        case (state_q)
            IDLE, I_CMD, D_CMD: begin
                stray_d = stray_q | mem_readdatavalid;
                if (issue_i) begin
                    if (!mem_waitrequest) begin
                        state_d = I_DATA;
                        beat_d  = BURST_LEN;
                    end else begin
                        state_d = I_CMD;
                    end
                end else if (issue_d) begin
                    if (!mem_waitrequest) begin
                        if (d_read) begin
                            state_d = D_DATA;
                            beat_d  = ONE_BEAT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = D_CMD;
                    end
                end else begin
                    // A master that withdraws a stalled request simply releases the port.
                    state_d = IDLE;
                end
            end
            I_DATA, D_DATA: begin
                if (mem_readdatavalid) begin
                    beat_d = beat_q - ONE_BEAT;
                    if (beat_q == ONE_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            perf_q     <= '0;
            stray_q    <= 1'b0;
`ifdef YARI_MEM_ARB_RR_EN
            prefer_d_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            perf_q     <= perf_d;
            stray_q    <= stray_d;
`ifdef YARI_MEM_ARB_RR_EN
            prefer_d_q <= prefer_d_d;
`endif
        end
    end

    assign perf_mem_conflicts = perf_q;
    assign err_stray_beat     = stray_q;

endmodule
